// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch / PC stage: fetches over a req/ack port, holds PC and the current
// instruction, computes the next PC from pcsource and traps misaligned targets and fetch timeouts.
//
// state   | meaning
// S_IDLE  | first cycle after reset release
// S_FETCH | imem_req high at pc, waiting for imem_ack
// S_EXEC  | inst live for decode/execute, next PC taken when not stalled
// S_FAULT | sticky fault, frozen until reset
module cpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        clrn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] ra_i,
    input  logic        exec_stall_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc4;
    logic [31:0]      npc;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        npc = pc4;
        unique case (pcsource_i)
            2'b00: npc = pc4;
            2'b01: npc = pc4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
            2'b10: npc = ra_i;
            2'b11: npc = {pc4[31:28], inst_q[25:0], 2'b00};
            default: npc = pc4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // Ack on the terminal-count cycle still wins over the timeout.
                if (imem_ack_i) begin
                    inst_d  = imem_rdata_i;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                    state_d    = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (!exec_stall_i) begin
                    if (npc[1:0] != 2'b00) begin
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        state_d    = S_FAULT;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_o   = (state_q == S_FETCH);
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (state_q == S_EXEC);
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign pc4_o        = pc4;
    assign fault_o      = fault_q;
    assign fault_pc_o   = fault_pc_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed cases plus a randomized instruction stream checked
// against an architectural PC model.
module tb_cpu_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] ra = '0;
    logic        exec_stall = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_faulted;

    cpu_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .clrn_i       (clrn),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .pcsource_i   (pcsource),
        .ra_i         (ra),
        .exec_stall_i (exec_stall),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .pc_o         (pc),
        .pc4_o        (pc4),
        .fault_o      (fault),
        .fault_pc_o   (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] w,
                                            input logic [1:0] ps, input logic [31:0] rav);
        int off;
        off = int'($signed(w[15:0]));
        case (ps)
            2'd0:    return cur + 32'd4;
            2'd1:    return cur + 32'd4 + 32'(off * 4);
            2'd2:    return rav;
            default: return ((cur + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        endcase
    endfunction

    task automatic do_reset();
        clrn = 1'b0; imem_ack = 1'b0; exec_stall = 1'b0; pcsource = 2'b00;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        clrn = 1'b1;
        @(negedge clk);
        m_pc = 32'h0; m_inst = 32'h0; m_faulted = 1'b0;
    endtask

    // Withhold ack for d cycles, then return word w.
    task automatic fetch(input logic [31:0] w, input int d);
        for (int i = 0; i < d; i++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_valid", 32'(inst_valid), 32'd0);
            chk("fetch_addr", imem_addr, m_pc);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        imem_ack = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        m_inst = w;
    endtask

    task automatic exec(input logic [1:0] ps, input logic [31:0] rav, input int stall);
        logic [31:0] npc;
        for (int i = 0; i <= stall; i++) begin
            chk("exec_valid", 32'(inst_valid), 32'd1);
            chk("exec_req", 32'(imem_req), 32'd0);
            chk("exec_inst", inst, m_inst);
            chk("exec_pc", pc, m_pc);
            chk("exec_pc4", pc4, m_pc + 32'd4);
            exec_stall = (i < stall);
            imem_ack = $urandom_range(0, 1);
            pcsource = ps; ra = rav;
            @(negedge clk);
        end
        exec_stall = 1'b0; imem_ack = 1'b0;
        npc = next_pc(m_pc, m_inst, ps, rav);
        if (npc % 4 != 0) begin
            chk("trap_fault", 32'(fault), 32'd1);
            chk("trap_fault_pc", fault_pc, m_pc);
            chk("trap_req", 32'(imem_req), 32'd0);
            chk("trap_pc", pc, m_pc);
            m_faulted = 1'b1;
        end else begin
            chk("exec_nofault", 32'(fault), 32'd0);
            m_pc = npc;
        end
    endtask

    task automatic hold_fault(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            chk("fault_sticky", 32'(fault), 32'd1);
            chk("fault_req", 32'(imem_req), 32'd0);
            chk("fault_valid", 32'(inst_valid), 32'd0);
            chk("fault_pc_frozen", pc, m_pc);
            chk("fault_inst_frozen", inst, m_inst);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // sequential fetch, zero-wait memory
        fetch(32'h0000_0000, 0); exec(2'b00, 32'h0, 0);
        chk("seq_addr4", imem_addr, 32'h4);
        fetch(32'h0000_0000, 0); exec(2'b00, 32'h0, 0);
        chk("seq_addr8", imem_addr, 32'h8);

        // branches from pc 0x100
        fetch(32'h0, 0); exec(2'b10, 32'h100, 0);
        fetch(32'h1000_FFFE, 0); exec(2'b01, 32'h0, 0);
        chk("beq_back", imem_addr, 32'h0FC);
        fetch(32'h0, 0); exec(2'b10, 32'h100, 0);
        fetch(32'h1000_7FFF, 0); exec(2'b01, 32'h0, 0);
        chk("beq_fwd", imem_addr, 32'h0002_0100);

        // jal
        fetch(32'h0, 0); exec(2'b10, 32'h40, 0);
        fetch(32'h0C00_0010, 0);
        chk("jal_pc4", pc4, 32'h44);
        exec(2'b11, 32'h0, 0);
        chk("jal_addr", imem_addr, 32'h40);
        fetch(32'h0, 0); exec(2'b10, 32'hF000_0000, 0);
        fetch(32'h0C00_0010, 0); exec(2'b11, 32'h0, 0);
        chk("jal_region", imem_addr, 32'hF000_0040);

        // jr good and misaligned
        fetch(32'h0, 1); exec(2'b10, 32'h2000, 0);
        chk("jr_addr", imem_addr, 32'h2000);
        fetch(32'h0, 2); exec(2'b10, 32'h2002, 0);
        chk("jr_fault_pc", fault_pc, 32'h2000);
        hold_fault(4);

        // ack arrives in the last allowed cycle
        do_reset();
        fetch(32'h1234_5678, TIMEOUT - 1);
        chk("late_ack_valid", 32'(inst_valid), 32'd1);
        chk("late_ack_fault", 32'(fault), 32'd0);
        exec(2'b00, 32'h0, 0);

        // timeout: ack withheld for TIMEOUT cycles
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_req", 32'(imem_req), 32'd1);
            chk("to_nofault", 32'(fault), 32'd0);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_fault_pc", fault_pc, 32'h4);
        hold_fault(3);

        // stall three cycles, then mid-FETCH reset
        do_reset();
        fetch(32'hABCD_0001, 0); exec(2'b00, 32'h0, 3);
        fetch(32'h0, 1);
        exec(2'b00, 32'h0, 0);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        clrn = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        chk("async_pc", pc, 32'h0);
        do_reset();
        chk("post_rst_addr", imem_addr, 32'h0);

        // randomized stream
        for (int n = 0; n < 150; n++) begin
            logic [31:0] w, rav;
            logic [1:0]  ps;
            int          d;
            w   = $urandom;
            ps  = 2'($urandom_range(0, 3));
            rav = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 11) == 0) rav[1:0] = 2'($urandom_range(1, 3));
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 2);
            fetch(w, d);
            exec(ps, rav, $urandom_range(0, 2));
            if (m_faulted) begin
                hold_fault(2);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
